// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
// Shared types and sizing helpers for the parallel-in / serial-out serializer.
//
// Build option: PISO_PARITY_EN appends one even-parity bit to every frame,
// so a frame is WIDTH+1 bits long instead of WIDTH.
// ---------------------------------------------------------------------------
package piso_pkg;

    // Controller states: waiting for a word, or emitting frame bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Number of serial cycles a single frame occupies.
    function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    // Bits needed by the bit counter to reach frame_len(width)-1.
    function automatic int count_width(input int width);
        return $clog2(frame_len(width));
    endfunction

    // Sizing for the default 4-bit configuration.
    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_COUNT_W = count_width(DEFAULT_WIDTH);

endpackage

// File: rtl/piso_bit_counter.sv
// ---------------------------------------------------------------------------
// piso_bit_counter
// Loadable up-counter that tracks which frame bit is currently on the line.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset (count -> 0)
//   clear      in   force count to 0
//   load       in   load load_value (priority below clear)
//   inc        in   increment by one (priority below load)
//   load_value in   value taken on load
//   count      out  current count
//   last       out  count equals LAST_VALUE (final bit of a frame)
// ---------------------------------------------------------------------------
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int COUNT_W    = DEFAULT_COUNT_W,
    parameter int LAST_VALUE = DEFAULT_WIDTH - 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic               inc,
    input  logic [COUNT_W-1:0] load_value,
    output logic [COUNT_W-1:0] count,
    output logic               last
);

    logic [COUNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (inc) begin
            count_reg <= count_reg + COUNT_W'(1);
        end
    end

    assign count = count_reg;
    assign last  = (count_reg == COUNT_W'(LAST_VALUE));

endmodule

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Parallel-in, serial-out transmitter. A WIDTH-bit word is taken through a
// valid/ready handshake and sent one bit per clock on sout, LSB first unless
// MSB_FIRST=1. The first bit appears the cycle after the handshake. During
// the last bit of a frame load_ready is high again, so frames can stream
// back-to-back with no idle cycle.
//
// Build option: PISO_PARITY_EN adds an even-parity bit after the data bits;
// frame_done and the reload window then fall on the parity cycle.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset; aborts any frame
//   load_valid  in   upstream offers load_data (held until accepted)
//   load_data   in   word to serialize
//   load_ready  out  word can be accepted this cycle (combinational)
//   sout        out  serial bit (0 whenever sout_valid=0), registered
//   sout_valid  out  sout carries a frame bit, registered
//   frame_done  out  pulse on the last bit of a frame, registered
//   busy        out  frame in progress, registered
// ---------------------------------------------------------------------------
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam int COUNT_W   = count_width(WIDTH);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   shift_reg, shift_next;
    logic               sout_reg, sout_next;
    logic               sout_valid_reg, sout_valid_next;
    logic               frame_done_reg, frame_done_next;
    logic               busy_reg, busy_next;
`ifdef PISO_PARITY_EN
    logic               parity_reg, parity_next;
`endif

    logic               accept;
    logic               advance;
    logic               clear;
    logic [COUNT_W-1:0] count;
    logic               last;

    piso_bit_counter #(
        .COUNT_W    (COUNT_W),
        .LAST_VALUE (FRAME_LEN - 1)
    ) u_bit_counter (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .load       (accept),
        .inc        (advance),
        .load_value ('0),
        .count      (count),
        .last       (last)
    );

    // Control: handshake, next state, counter commands.
    always_comb begin
        state_next = state_reg;
        advance    = 1'b0;
        clear      = 1'b0;
        load_ready = (state_reg == IDLE) || ((state_reg == SHIFT) && last);
        accept     = load_valid && load_ready;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    // Without a new word the frame ends and the line goes idle.
                    if (!accept) begin
                        state_next = IDLE;
                        clear      = 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: the bit for the next cycle is computed here and registered,
    // so the count value always names the bit currently on sout.
    always_comb begin
        shift_next      = shift_reg;
        sout_next       = 1'b0;
        sout_valid_next = 1'b0;
        frame_done_next = 1'b0;
        busy_next       = 1'b0;
`ifdef PISO_PARITY_EN
        parity_next     = parity_reg;
`endif

        if (accept) begin
            // The first bit goes straight to sout; the shifter keeps the rest.
            if (MSB_FIRST != 0) begin
                sout_next  = load_data[WIDTH-1];
                shift_next = load_data << 1;
            end else begin
                sout_next  = load_data[0];
                shift_next = load_data >> 1;
            end
            sout_valid_next = 1'b1;
            busy_next       = 1'b1;
`ifdef PISO_PARITY_EN
            parity_next     = ^load_data;
`endif
        end else if (advance) begin
            if (MSB_FIRST != 0) begin
                sout_next  = shift_reg[WIDTH-1];
                shift_next = shift_reg << 1;
            end else begin
                sout_next  = shift_reg[0];
                shift_next = shift_reg >> 1;
            end
`ifdef PISO_PARITY_EN
            // Leaving the final data bit: the parity bit follows.
            if (count == COUNT_W'(WIDTH - 1)) begin
                sout_next = parity_reg;
            end
`endif
            sout_valid_next = 1'b1;
            busy_next       = 1'b1;
            // Registered pulse lands on the cycle that carries the last bit.
            frame_done_next = (count == COUNT_W'(FRAME_LEN - 2));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            sout_reg       <= 1'b0;
            sout_valid_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_reg     <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            sout_reg       <= sout_next;
            sout_valid_reg <= sout_valid_next;
            frame_done_reg <= frame_done_next;
            busy_reg       <= busy_next;
`ifdef PISO_PARITY_EN
            parity_reg     <= parity_next;
`endif
        end
    end

    assign sout       = sout_reg;
    assign sout_valid = sout_valid_reg;
    assign frame_done = frame_done_reg;
    assign busy       = busy_reg;

endmodule
